rcl_stream: RTL
===============

# rcl_stream

Parametrised, fully pipelined line–circle intersection classifier. It accepts a stream of three-beat packets, each describing a line a·x + b·y + c = 0 and a circle (x−m)² + (y−n)² = k. For each packet it reports 0, 1 or 2 intersections. It sits in the same online-test datapath as the single-shot RCL classifier and adds several things that block lacks: back-to-back packets, in_valid gaps inside a packet, a fixed-latency pipeline, a partial-packet timeout and a configurable coefficient width.

## Interface
- W, default 5: coefficient width. coef_L is signed W bits; coef_Q is W bits, signed on beats 0–1 and unsigned on beat 2.
- TIMEOUT, default 15: number of consecutive in_valid-low cycles inside a partial packet before that packet is dropped. 0 disables the timeout.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  1  beat qualifier; a beat is accepted on every edge where in_valid=1.
- coef_L  input  W  line coefficient: beat 0 = a, beat 1 = b, beat 2 = c (signed).
- coef_Q  input  W  circle coefficient: beat 0 = m, beat 1 = n (signed), beat 2 = k (unsigned radius²).
- out_valid  output  1  one-cycle pulse per completed packet.
- out  output  2  intersection count: 2'd0, 2'd1 or 2'd2. Forced to 0 whenever out_valid=0.
- err  output  1  one-cycle pulse when a partial packet is dropped by the timeout.

## Operation
- Beat-collector FSM with three states:
  - S0: waiting for beat 0.
  - S1: holding a, m.
  - S2: holding a, m, b, n.
- Transitions:
  - An accepted beat advances S0→S1→S2→S0.
  - The S2→S0 advance captures c and k, then launches the packet into the pipeline with a valid bit.
- in_valid=0 holds the state; gaps of any length below TIMEOUT are legal between beats.
- The idle counter counts consecutive in_valid=0 edges while in S1 or S2.
  - It clears on any accepted beat and in S0.
  - When it reaches TIMEOUT (TIMEOUT>0), the FSM returns to S0, the partial coefficients are discarded, and err=1 for one cycle.
  - The next accepted beat is treated as beat 0.
- A timeout never affects packets already in the pipeline.
- Pipeline stages:
  - P1: register a·m and b·n (2W signed each), a² and b² (2W unsigned each), c and k.
  - P2: s = a·m + b·n + c, sign-extended to 2W+2 bits; q = a² + b² (2W+1 bits unsigned); k forwarded.
  - P3: rhs = s² (4W+4 bits unsigned); lhs = q·k (3W+1 bits).
  - P4: compare lhs against rhs, zero-extended to a common width.
    - lhs > rhs → out=2
    - lhs == rhs → out=1
    - otherwise → out=0
- All arithmetic is full precision; no truncation or saturation at any stage.
- k=0 is legal: the result is 1 if s=0, otherwise 0.
- A degenerate line (a=b=0) follows the same formula and is not flagged.
- Each pipeline stage carries its own valid bit; there is no backpressure and no stall.

## Timing
- Reset (rst_n=0 at an edge) clears all of the following on that same edge:
  - FSM to S0 and idle counter to 0.
  - Every pipeline valid bit, and the coefficient registers.
  - out_valid=0, out=0, err=0.
- Reset mid-packet or mid-pipeline discards all in-flight work; no out_valid pulse follows for any packet that was in flight.
- Latency: if beat 2 is accepted at edge E, then out_valid=1 and out are valid in the cycle after edge E+4. This is fixed at 4 edges regardless of gaps.
- Throughput: one packet per 3 accepted beats. Consecutive packets with no gaps produce an out_valid pulse every 3rd cycle.
- On an edge where in_valid=1 and the idle count would reach TIMEOUT, the beat is accepted and no err is raised.
- err and out_valid may be high in the same cycle; they are independent.

## Test plan
- W=5, beats (L,Q) = (1,0),(0,0),(0,4): line x=0, circle r=2. Expect out_valid after 4 edges and out=2.
- Beats (1,0),(0,0),(−2,4): s=−2, rhs=4, lhs=4 → out=1. Beats (1,0),(0,0),(−3,4): rhs=9 > lhs=4 → out=0.
- Three packets back-to-back with no gaps (expected results 2, 1, 0): out_valid pulses at cycles E+4, E+7, E+10 with those values in order.
- Extreme values a=b=m=n=c=−16, k=31: s=496, rhs=246016, lhs=15872 → out=0. This checks that no overflow occurs.
- TIMEOUT=15: send beat 0, then hold in_valid=0 for 15 cycles. Expect err pulses once and no out_valid. The next packet (1,0),(0,0),(0,4) → out=2. A 14-cycle gap inside a packet gives no err and a correct result.
- Assert rst_n=0 for 1 cycle while two packets are in the pipeline. Expect out_valid/out/err=0 from that edge, with no stale pulses afterwards. A fresh packet then completes with 4-edge latency.

Source files
------------

// File: rtl/rcl_stream.sv
// rcl_stream: pipelined line-circle intersection counter over three-beat packets,
// with a partial-packet timeout and a fixed 4-edge launch-to-output latency.
module rcl_stream #(
  parameter int W = 5,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] coef_L,
  input  logic [W-1:0] coef_Q,
  output logic         out_valid,
  output logic [1:0]   out,
  output logic         err
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 2;
  localparam int QW = 2 * W + 1;
  localparam int RW = 4 * W + 4;
  localparam int LW = 3 * W + 1;
  typedef enum logic [1:0] {S0, S1, S2} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] idle, idle_nxt;
  logic err_nxt, launch;
  logic signed [W-1:0] a_h, m_h, b_h, n_h;
  logic signed [W-1:0] a0, m0, b0, n0, c0;
  logic [W-1:0] k0;
  logic v0;
  logic signed [PW-1:0] am1, bn1;
  logic [PW-1:0] aa1, bb1;
  logic signed [W-1:0] c1;
  logic [W-1:0] k1;
  logic v1;
  logic signed [SW-1:0] s2;
  logic [QW-1:0] q2;
  logic [W-1:0] k2;
  logic v2;
  logic [RW-1:0] rhs3;
  logic [LW-1:0] lhs3;
  logic v3;
  logic signed [PW-1:0] ea, em, eb, en;
  logic signed [RW-1:0] es;
  always_comb begin
    state_nxt = state;
    idle_nxt = '0;
    err_nxt = 1'b0;
    launch = 1'b0;
    if (in_valid) begin
      state_nxt = state == S0 ? S1 : state == S1 ? S2 : S0;
      launch = state == S2;
    end else if (state != S0 && TIMEOUT > 0) begin
      if (idle == CW'(TIMEOUT - 1)) begin
        state_nxt = S0;
        err_nxt = 1'b1;
      end else begin
        idle_nxt = idle + CW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S0;
      idle <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      idle <= idle_nxt;
      err <= err_nxt;
    end
  end
  // Launch registers decouple the next packet's beats from the one entering P1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {a_h, m_h, b_h, n_h} <= '0;
      {a0, m0, b0, n0, c0, k0} <= '0;
      v0 <= 1'b0;
    end else begin
      if (in_valid && state == S0) {a_h, m_h} <= {coef_L, coef_Q};
      if (in_valid && state == S1) {b_h, n_h} <= {coef_L, coef_Q};
      v0 <= launch;
      if (launch) {a0, m0, b0, n0, c0, k0} <= {a_h, m_h, b_h, n_h, coef_L, coef_Q};
    end
  end
  always_comb begin
    ea = PW'(a0);
    em = PW'(m0);
    eb = PW'(b0);
    en = PW'(n0);
    es = RW'(s2);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {am1, bn1, aa1, bb1, c1, k1, v1} <= '0;
      {s2, q2, k2, v2} <= '0;
      {rhs3, lhs3, v3} <= '0;
      out_valid <= 1'b0;
      out <= 2'd0;
    end else begin
      am1 <= ea * em;
      bn1 <= eb * en;
      aa1 <= $unsigned(ea * ea);
      bb1 <= $unsigned(eb * eb);
      c1 <= c0;
      k1 <= k0;
      v1 <= v0;
      s2 <= SW'(am1) + SW'(bn1) + SW'(c1);
      q2 <= QW'(aa1) + QW'(bb1);
      k2 <= k1;
      v2 <= v1;
      rhs3 <= $unsigned(es * es);
      lhs3 <= LW'(q2) * LW'(k2);
      v3 <= v2;
      out_valid <= v3;
      out <= !v3 ? 2'd0 : RW'(lhs3) > rhs3 ? 2'd2 : RW'(lhs3) == rhs3 ? 2'd1 : 2'd0;
    end
  end
endmodule
